// File: rtl/led_seq_pkg.sv
// ============================================================================
// Module      : led_seq_pkg
// Description : Shared constants and types for the LED PIO sequencer:
//               configuration register map, CTRL/STATUS bit positions,
//               sequencer state encoding and the PIO data register offset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_seq_pkg;

    // Configuration slave word addresses
    localparam logic [4:0] c_addr_ctrl      = 5'd0;
    localparam logic [4:0] c_addr_period    = 5'd1;
    localparam logic [4:0] c_addr_length    = 5'd2;
    localparam logic [4:0] c_addr_status    = 5'd3;
    localparam logic [4:0] c_addr_ptrn_base = 5'd16;

    // CTRL bit positions
    localparam int c_ctrl_run_bit     = 0;
    localparam int c_ctrl_oneshot_bit = 1;

    // STATUS bit positions
    localparam int c_status_busy_bit = 0;
    localparam int c_status_idx_lsb  = 4;
    localparam int c_status_wrap_bit = 8;

    // Word offset of the data register inside the LED PIO
    localparam logic [1:0] c_pio_data_offset = 2'd0;

    // Sequencer states; ST_BLANK is only reachable when the blank-on-stop
    // feature is built in.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITE     = 2'd1,
        ST_WAIT_TICK = 2'd2,
        ST_BLANK     = 2'd3
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/led_seq_tick.sv
// ============================================================================
// Module      : led_seq_tick
// Description : Loadable down-counter that times the gap between pattern
//               steps. Load has priority over enable; the count holds at
//               zero and 'zero' flags that condition.
// Ports       : clk, reset_n    - clock, asynchronous active-low reset
//               load, load_value - synchronous load of the start count
//               enable           - decrement while nonzero
//               zero             - count equals zero
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_seq_tick
    import led_seq_pkg::*;
#(
    parameter int TICK_W = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [TICK_W-1:0] load_value,
    input  logic              enable,
    output logic              zero
);

    logic [TICK_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (enable && (r_count != '0)) begin
            r_count <= r_count - TICK_W'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/led_pio_sequencer.sv
// ============================================================================
// Module      : led_pio_sequencer
// Description : Autonomous Avalon-MM master that steps a software-loaded
//               pattern table into the LED PIO data register at a
//               programmable rate. Configured through a small Avalon-MM
//               slave (CTRL, PERIOD, LENGTH, STATUS, pattern table).
// Ports       : clk, reset_n        - clock, asynchronous active-low reset
//               cfg_*               - configuration slave (zero wait states)
//               pio_*               - PIO master (write-only, honours
//                                     waitrequest)
//               busy                - sequencer not idle
//               wrap_irq            - one-cycle pulse on table wrap
// Build macro : LED_SEQ_BLANK_EN - when defined, every stop issues one extra
//               PIO write of zero (LEDs off) before returning to idle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pio_sequencer
    import led_seq_pkg::*;
#(
    parameter int PTRN_DEPTH = 8,
    parameter int PTRN_W     = 8,
    parameter int TICK_W     = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  cfg_address,
    input  logic        cfg_chipselect,
    input  logic        cfg_write_n,
    input  logic [31:0] cfg_writedata,
    output logic [31:0] cfg_readdata,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    input  logic        pio_waitrequest,
    output logic        busy,
    output logic        wrap_irq
);

    localparam int         c_idx_w    = $clog2(PTRN_DEPTH);
    localparam int         c_len_w    = c_idx_w + 1;
    localparam logic [5:0] c_ptrn_lo  = {1'b0, c_addr_ptrn_base};
    localparam logic [5:0] c_ptrn_end = 6'(int'(c_addr_ptrn_base) + PTRN_DEPTH);

    // Configuration state
    logic                r_run;
    logic                r_oneshot;
    logic [TICK_W-1:0]   r_period;
    logic [c_len_w-1:0]  r_length;
    logic                r_wrap_sticky;
    logic [PTRN_W-1:0]   r_ptrn [PTRN_DEPTH];

    // Sequencer state
    seq_state_t          r_state;
    logic [c_idx_w-1:0]  r_index;
    logic                r_pio_cs;
    logic                r_pio_wr_n;
    logic [PTRN_W-1:0]   r_pio_data;
    logic                r_wrap_irq;

    logic                w_cfg_wr;
    logic                w_addr_is_ptrn;
    logic [c_idx_w-1:0]  w_ptrn_sel;
    logic [c_len_w-1:0]  w_len_eff;
    logic [TICK_W-1:0]   w_period_m1;
    logic                w_tick_zero;
    logic                w_write_done;
    logic                w_step;
    logic                w_wrap;
    logic [c_idx_w-1:0]  w_index_next;
    logic                w_oneshot_done;
    logic                w_seq_stop;

    // ------------------------------------------------------------------
    // Decode and derived values
    // ------------------------------------------------------------------
    assign w_cfg_wr       = cfg_chipselect && !cfg_write_n;
    assign w_addr_is_ptrn = ({1'b0, cfg_address} >= c_ptrn_lo) &&
                            ({1'b0, cfg_address} <  c_ptrn_end);
    // The table base is 16-aligned and the depth is at most 16, so the low
    // address bits select the entry directly.
    assign w_ptrn_sel     = cfg_address[c_idx_w-1:0];

    // LENGTH is stored already clamped to the depth; zero still means one.
    assign w_len_eff      = (r_length == '0) ? c_len_w'(1) : r_length;
    assign w_period_m1    = (r_period == '0) ? '0 : r_period - TICK_W'(1);

    assign w_write_done   = (r_state == ST_WRITE) && !pio_waitrequest;
    assign w_step         = (r_state == ST_WAIT_TICK) && r_run && w_tick_zero;
    // '>=' rather than '==' so a LENGTH shrunk below the current index
    // still wraps at the next step.
    assign w_wrap         = w_step &&
                            ({1'b0, r_index} >= (w_len_eff - c_len_w'(1)));
    assign w_index_next   = w_wrap ? '0 : r_index + c_idx_w'(1);
    assign w_oneshot_done = w_wrap && r_oneshot;
    // Software clear of RUN takes priority over a pending step.
    assign w_seq_stop     = (r_state == ST_WAIT_TICK) && (!r_run || w_oneshot_done);

    // ------------------------------------------------------------------
    // Step timer: loaded on write completion, counts only while waiting
    // ------------------------------------------------------------------
    led_seq_tick #(
        .TICK_W (TICK_W)
    ) u_tick (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (w_write_done),
        .load_value (w_period_m1),
        .enable     (r_state == ST_WAIT_TICK),
        .zero       (w_tick_zero)
    );

    // ------------------------------------------------------------------
    // Configuration registers and pattern table
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run         <= 1'b0;
            r_oneshot     <= 1'b0;
            r_period      <= '0;
            r_length      <= '0;
            r_wrap_sticky <= 1'b0;
            for (int i = 0; i < PTRN_DEPTH; i++) begin
                r_ptrn[i] <= '0;
            end
        end else begin
            if (w_cfg_wr) begin
                case (cfg_address)
                    c_addr_ctrl: begin
                        r_run     <= cfg_writedata[c_ctrl_run_bit];
                        r_oneshot <= cfg_writedata[c_ctrl_oneshot_bit];
                    end
                    c_addr_period: r_period <= cfg_writedata[TICK_W-1:0];
                    c_addr_length: begin
                        if (cfg_writedata > 32'(PTRN_DEPTH)) begin
                            r_length <= c_len_w'(PTRN_DEPTH);
                        end else begin
                            r_length <= cfg_writedata[c_len_w-1:0];
                        end
                    end
                    default: begin
                        if (w_addr_is_ptrn) begin
                            r_ptrn[w_ptrn_sel] <= cfg_writedata[PTRN_W-1:0];
                        end
                    end
                endcase
            end

            // A completed one-shot pass drops RUN, overriding a same-cycle write.
            if (w_oneshot_done) begin
                r_run <= 1'b0;
            end

            // Hardware set beats a same-cycle software clear.
            if (w_wrap) begin
                r_wrap_sticky <= 1'b1;
            end else if (w_cfg_wr && (cfg_address == c_addr_status) &&
                         cfg_writedata[c_status_wrap_bit]) begin
                r_wrap_sticky <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM with registered PIO master outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_index    <= '0;
            r_pio_cs   <= 1'b0;
            r_pio_wr_n <= 1'b1;
            r_pio_data <= '0;
            r_wrap_irq <= 1'b0;
        end else begin
            r_wrap_irq <= 1'b0;
            case (r_state)
                // RUN is level-checked here: the only way to sit in IDLE with
                // RUN set is a fresh 0->1 write, so this starts one cycle after
                // that write and also recovers from a clear/set during a stop.
                ST_IDLE: begin
                    if (r_run) begin
                        r_index    <= '0;
                        r_pio_data <= r_ptrn[0];
                        r_pio_cs   <= 1'b1;
                        r_pio_wr_n <= 1'b0;
                        r_state    <= ST_WRITE;
                    end
                end

                // Outputs hold while stalled; an in-flight write is never aborted.
                ST_WRITE: begin
                    if (!pio_waitrequest) begin
                        r_pio_cs   <= 1'b0;
                        r_pio_wr_n <= 1'b1;
                        if (r_run) begin
                            r_state <= ST_WAIT_TICK;
                        end else begin
`ifdef LED_SEQ_BLANK_EN
                            r_pio_data <= '0;
                            r_pio_cs   <= 1'b1;
                            r_pio_wr_n <= 1'b0;
                            r_state    <= ST_BLANK;
`else
                            r_state    <= ST_IDLE;
`endif
                        end
                    end
                end

                ST_WAIT_TICK: begin
                    if (w_step) begin
                        r_index    <= w_index_next;
                        r_wrap_irq <= w_wrap;
                    end
                    if (w_seq_stop) begin
`ifdef LED_SEQ_BLANK_EN
                        r_pio_data <= '0;
                        r_pio_cs   <= 1'b1;
                        r_pio_wr_n <= 1'b0;
                        r_state    <= ST_BLANK;
`else
                        r_state    <= ST_IDLE;
`endif
                    end else if (w_step) begin
                        // Latch the entry now so later table writes cannot
                        // disturb the transfer in flight.
                        r_pio_data <= r_ptrn[w_index_next];
                        r_pio_cs   <= 1'b1;
                        r_pio_wr_n <= 1'b0;
                        r_state    <= ST_WRITE;
                    end
                end

`ifdef LED_SEQ_BLANK_EN
                ST_BLANK: begin
                    if (!pio_waitrequest) begin
                        r_pio_cs   <= 1'b0;
                        r_pio_wr_n <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
`endif

                default: begin
                    r_pio_cs   <= 1'b0;
                    r_pio_wr_n <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Configuration read mux (combinational, zero wait states)
    // ------------------------------------------------------------------
    always_comb begin
        cfg_readdata = '0;
        case (cfg_address)
            c_addr_ctrl: begin
                cfg_readdata[c_ctrl_run_bit]     = r_run;
                cfg_readdata[c_ctrl_oneshot_bit] = r_oneshot;
            end
            c_addr_period: cfg_readdata = 32'(r_period);
            c_addr_length: cfg_readdata = 32'(r_length);
            c_addr_status: begin
                cfg_readdata[c_status_busy_bit]        = (r_state != ST_IDLE);
                cfg_readdata[c_status_idx_lsb +: 4]    = 4'(r_index);
                cfg_readdata[c_status_wrap_bit]        = r_wrap_sticky;
            end
            default: begin
                if (w_addr_is_ptrn) begin
                    cfg_readdata = 32'(r_ptrn[w_ptrn_sel]);
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pio_address    = c_pio_data_offset;
    assign pio_chipselect = r_pio_cs;
    assign pio_write_n    = r_pio_wr_n;
    assign pio_writedata  = 32'(r_pio_data);
    assign busy           = (r_state != ST_IDLE);
    assign wrap_irq       = r_wrap_irq;

endmodule

`default_nettype wire

// File: tb/tb_led_pio_sequencer.sv
// ============================================================================
// Module      : tb_led_pio_sequencer
// Description : Directed self-checking bench for led_pio_sequencer. A bus
//               monitor logs every completed PIO write (data and cycle) and
//               counts wrap_irq pulses; the initial block steps through the
//               scenarios and compares against hand-computed values.
// Build macro : LED_SEQ_BLANK_EN selects the blank-on-stop expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_led_pio_sequencer;

    localparam int PTRN_DEPTH = 8;
    localparam int PTRN_W     = 8;
    localparam int TICK_W     = 24;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  cfg_address;
    logic        cfg_chipselect;
    logic        cfg_write_n;
    logic [31:0] cfg_writedata;
    logic [31:0] cfg_readdata;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic        pio_waitrequest;
    logic        busy;
    logic        wrap_irq;

    always #5 clk = ~clk;

    led_pio_sequencer #(
        .PTRN_DEPTH (PTRN_DEPTH),
        .PTRN_W     (PTRN_W),
        .TICK_W     (TICK_W)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cfg_address     (cfg_address),
        .cfg_chipselect  (cfg_chipselect),
        .cfg_write_n     (cfg_write_n),
        .cfg_writedata   (cfg_writedata),
        .cfg_readdata    (cfg_readdata),
        .pio_address     (pio_address),
        .pio_chipselect  (pio_chipselect),
        .pio_write_n     (pio_write_n),
        .pio_writedata   (pio_writedata),
        .pio_waitrequest (pio_waitrequest),
        .busy            (busy),
        .wrap_irq        (wrap_irq)
    );

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc    = 0;
    int          wrap_cnt = 0;
    logic [31:0] wr_data_q [$];
    int unsigned wr_cyc_q  [$];

    // Bus monitor: a write completes on a clock edge with cs=1, write_n=0,
    // waitrequest=0.
    always @(posedge clk) begin
        if (reset_n && pio_chipselect && !pio_write_n && !pio_waitrequest) begin
            wr_data_q.push_back(pio_writedata);
            wr_cyc_q.push_back(cyc);
        end
        if (reset_n && wrap_irq) begin
            wrap_cnt++;
        end
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cfg_wr(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        cfg_address    = addr;
        cfg_writedata  = data;
        cfg_chipselect = 1'b1;
        cfg_write_n    = 1'b0;
        @(negedge clk);
        cfg_chipselect = 1'b0;
        cfg_write_n    = 1'b1;
    endtask

    task automatic cfg_rd(input logic [4:0] addr, output logic [31:0] data);
        cfg_address = addr;
        #1;
        data = cfg_readdata;
    endtask

    task automatic wait_cs(input string tag, input int max_cyc);
        int n = 0;
        while (!pio_chipselect && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(pio_chipselect), 32'd1);
    endtask

    task automatic wait_busy(input string tag, input logic val, input int max_cyc);
        int n = 0;
        while ((busy !== val) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'(val));
    endtask

    task automatic wait_writes(input string tag, input int total, input int max_cyc);
        int n = 0;
        while ((wr_data_q.size() < total) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(wr_data_q.size() >= total), 32'd1);
    endtask

    logic [31:0] rd;
    int          b;
    int          wb;
    logic [7:0]  exp2 [7] = '{8'h01, 8'h02, 8'h04, 8'h01, 8'h02, 8'h04, 8'h01};

    initial begin
        reset_n         = 1'b0;
        cfg_address     = '0;
        cfg_chipselect  = 1'b0;
        cfg_write_n     = 1'b1;
        cfg_writedata   = '0;
        pio_waitrequest = 1'b0;
        repeat (3) @(negedge clk);

        // ---------------- Reset state ----------------
        check("rst_cs",      32'(pio_chipselect), 32'd0);
        check("rst_wr_n",    32'(pio_write_n),    32'd1);
        check("rst_wdata",   pio_writedata,       32'd0);
        check("rst_busy",    32'(busy),           32'd0);
        check("rst_irq",     32'(wrap_irq),       32'd0);
        check("rst_addr",    32'(pio_address),    32'd0);
        cfg_rd(5'd2, rd);  check("rst_length", rd, 32'd0);
        cfg_rd(5'd3, rd);  check("rst_status", rd, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // ---------------- T1: reset during a stalled write ----------------
        pio_waitrequest = 1'b1;
        cfg_wr(5'd16, 32'h5A);
        cfg_wr(5'd0,  32'h1);
        wait_cs("t1_cs_up", 10);
        check("t1_data",  pio_writedata, 32'h0000005A);
        check("t1_busy",  32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t1_cs",    32'(pio_chipselect), 32'd0);
        check("t1_wr_n",  32'(pio_write_n),    32'd1);
        check("t1_busy0", 32'(busy),           32'd0);
        cfg_rd(5'd0,  rd); check("t1_ctrl",   rd, 32'd0);
        cfg_rd(5'd16, rd); check("t1_ptrn0",  rd, 32'd0);
        cfg_rd(5'd3,  rd); check("t1_status", rd, 32'd0);
        @(negedge clk);
        reset_n         = 1'b1;
        pio_waitrequest = 1'b0;

        // ---------------- T2: 3-entry table, PERIOD=4 ----------------
        cfg_wr(5'd16, 32'h01);
        cfg_wr(5'd17, 32'h02);
        cfg_wr(5'd18, 32'h04);
        cfg_wr(5'd2,  32'd3);
        cfg_wr(5'd1,  32'd4);
        cfg_rd(5'd1, rd); check("t2_period_rd", rd, 32'd4);
        b  = wr_data_q.size();
        wb = wrap_cnt;
        cfg_wr(5'd0, 32'h1);
        wait_writes("t2_writes", b + 7, 100);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("t2_data%0d", i), wr_data_q[b+i], 32'(exp2[i]));
            if (i > 0) begin
                // Transfer takes one cycle plus PERIOD cycles of step latency.
                check($sformatf("t2_gap%0d", i), 32'(wr_cyc_q[b+i] - wr_cyc_q[b+i-1]), 32'd5);
            end
        end
        check("t2_wraps", 32'(wrap_cnt - wb), 32'd2);
        cfg_rd(5'd3, rd); check("t2_wrap_sticky", 32'(rd[8]), 32'd1);
        cfg_wr(5'd0, 32'h0);
        wait_busy("t2_stop", 1'b0, 20);

        // ---------------- T3: 5-cycle stall on 0xA5 ----------------
        cfg_wr(5'd16, 32'hA5);
        cfg_wr(5'd2,  32'd1);
        cfg_wr(5'd1,  32'd3);
        pio_waitrequest = 1'b1;
        cfg_wr(5'd0, 32'h1);
        wait_cs("t3_cs_up", 10);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t3_cs%0d", i),    32'(pio_chipselect), 32'd1);
            check($sformatf("t3_wr_n%0d", i),  32'(pio_write_n),    32'd0);
            check($sformatf("t3_data%0d", i),  pio_writedata,       32'h000000A5);
            if (i == 5) pio_waitrequest = 1'b0;
            @(negedge clk);
        end
        check("t3_cs_done", 32'(pio_chipselect), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("t3_cs_wait2", 32'(pio_chipselect), 32'd0);
        @(negedge clk);
        check("t3_cs_next",  32'(pio_chipselect), 32'd1);
        cfg_wr(5'd0, 32'h0);
        wait_busy("t3_stop", 1'b0, 20);

        // ---------------- T4: ONESHOT, 2 entries ----------------
        cfg_wr(5'd3, 32'h100);
        cfg_rd(5'd3, rd); check("t4_wrap_clr0", 32'(rd[8]), 32'd0);
        cfg_wr(5'd16, 32'h11);
        cfg_wr(5'd17, 32'h22);
        cfg_wr(5'd2,  32'd2);
        cfg_wr(5'd1,  32'd2);
        b  = wr_data_q.size();
        wb = wrap_cnt;
        cfg_wr(5'd0, 32'h3);
        wait_busy("t4_busy1", 1'b1, 10);
        wait_busy("t4_busy0", 1'b0, 40);
        repeat (6) @(negedge clk);
`ifdef LED_SEQ_BLANK_EN
        check("t4_nwrites", 32'(wr_data_q.size() - b), 32'd3);
        check("t4_blank",   wr_data_q[b+2], 32'h00);
`else
        check("t4_nwrites", 32'(wr_data_q.size() - b), 32'd2);
`endif
        check("t4_data0", wr_data_q[b],   32'h11);
        check("t4_data1", wr_data_q[b+1], 32'h22);
        check("t4_wraps", 32'(wrap_cnt - wb), 32'd1);
        cfg_rd(5'd0, rd); check("t4_ctrl",   rd, 32'h2);
        cfg_rd(5'd3, rd); check("t4_status", rd, 32'h100);
        cfg_wr(5'd3, 32'h100);
        cfg_rd(5'd3, rd); check("t4_status_clr", rd, 32'h0);

        // ---------------- T5: clear RUN during stalled write ----------------
        cfg_wr(5'd16, 32'h33);
        cfg_wr(5'd2,  32'd1);
        cfg_wr(5'd1,  32'd2);
        pio_waitrequest = 1'b1;
        b = wr_data_q.size();
        cfg_wr(5'd0, 32'h1);
        wait_cs("t5_cs_up", 10);
        cfg_wr(5'd0, 32'h0);
        check("t5_cs_hold",   32'(pio_chipselect), 32'd1);
        check("t5_data_hold", pio_writedata, 32'h00000033);
        check("t5_busy_hold", 32'(busy), 32'd1);
        pio_waitrequest = 1'b0;
        wait_busy("t5_stop", 1'b0, 20);
        repeat (4) @(negedge clk);
        check("t5_data0", wr_data_q[b], 32'h33);
`ifdef LED_SEQ_BLANK_EN
        check("t5_nwrites", 32'(wr_data_q.size() - b), 32'd2);
        check("t5_blank",   wr_data_q[b+1], 32'h00);
        check("t5_led",     pio_writedata, 32'h0);
`else
        check("t5_nwrites", 32'(wr_data_q.size() - b), 32'd1);
        check("t5_led",     pio_writedata, 32'h33);
`endif

        // ---------------- T6: PERIOD=0, LENGTH=20 clamps to 8 ----------------
        for (int i = 0; i < PTRN_DEPTH; i++) begin
            cfg_wr(5'(16 + i), 32'(8'h10 + i));
        end
        cfg_wr(5'd24, 32'hFF);
        cfg_rd(5'd24, rd); check("t6_unmapped24", rd, 32'd0);
        cfg_wr(5'd5, 32'hFFFF);
        cfg_rd(5'd5, rd);  check("t6_unmapped5",  rd, 32'd0);
        cfg_wr(5'd1, 32'd0);
        cfg_wr(5'd2, 32'd20);
        b  = wr_data_q.size();
        wb = wrap_cnt;
        cfg_wr(5'd0, 32'h1);
        wait_writes("t6_writes", b + 10, 60);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t6_data%0d", i), wr_data_q[b+i], 32'(8'h10 + (i % 8)));
            if (i > 0) begin
                check($sformatf("t6_gap%0d", i), 32'(wr_cyc_q[b+i] - wr_cyc_q[b+i-1]), 32'd2);
            end
        end
        check("t6_wraps", 32'(wrap_cnt - wb), 32'd1);
        cfg_wr(5'd0, 32'h0);
        wait_busy("t6_stop", 1'b0, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
